sb_timer: RTL
=============

Name: sb_timer

Overview:
- Parametrised successor of the scoreboard timing block; runs on clk_25 and feeds the digit mux.
- Provides NUM_DIGITS BCD-style digit counters, each with its own modulus.
- Supports count-up and count-down modes, with start/stop/clear/load control.
- Emits a registered one-cycle tick per step, a wrap pulse in count-up mode and a done flag in count-down mode.

Parameters:
ONE_SEC, 25000000, clk_sbt cycles per count step; legal range >= 2
NUM_DIGITS, 4, number of digit counters; legal range 1..8; digit 0 is least significant
DIGIT_W, 4, bits per digit
DIGIT_MOD, {4'd6,4'd10,4'd6,4'd10}, packed per-digit modulus, MSD first; each field must be 2..10 (default = mm:ss)

Ports:
clk_sbt  in  1  clock (clk_25 domain)
rst_sbt  in  1  synchronous active-high reset
start_sbt  in  1  pulse; begin or resume counting
stop_sbt  in  1  pulse; pause counting
clear_sbt  in  1  pulse; zero all digits and return to IDLE
load_sbt  in  1  pulse; preload digits from load_val_sbt
load_val_sbt  in  NUM_DIGITS*DIGIT_W  preload value, packed, digit 0 in LSBs
dir_sbt  in  1  0 = count up, 1 = count down; sampled at every step
digits_out  out  NUM_DIGITS*DIGIT_W  current digits, packed, digit 0 in LSBs
running_out  out  1  high while in RUN
tick_out  out  1  one-cycle pulse, coincident with each digits_out change caused by a step
wrap_out  out  1  one-cycle pulse when count-up wraps from all-max to all-zero
done_out  out  1  level; high in DONE

Behaviour:
- Reset (rst_sbt high at a clock edge): state IDLE, prescaler 0, digits_out 0, running_out 0, tick_out 0, wrap_out 0, done_out 0. Reset overrides every other input.
- States:
  - IDLE: after reset or clear.
  - RUN: counting.
  - PAUSE: stopped with the value held.
  - DONE: count-down reached zero.
- Command priority, evaluated in the same cycle: clear > load > stop > start.
- clear, from any state: next state IDLE, digits 0, prescaler 0, done_out 0.
- load, from any state: digits <= load_val_sbt, prescaler 0, next state PAUSE. Any field >= its modulus is clamped to modulus-1. Load clears done_out.
- stop: RUN -> PAUSE, prescaler held. Ignored in other states.
- start:
  - IDLE/PAUSE -> RUN, prescaler continues from its held value.
  - Ignored in RUN and DONE.
  - If dir_sbt=1 and all digits are 0 when start is applied: go to DONE instead of RUN. done_out rises the next cycle; no tick.
- Prescaler: in RUN, increments each cycle; it wraps 0..ONE_SEC-1. When prescaler==ONE_SEC-1, a step occurs on that edge.
- Step update: digits update on the same edge as the step. tick_out is registered high for exactly the one cycle in which the new digits are first visible.
- Step timing: the first step after start from IDLE appears ONE_SEC cycles after start is sampled.
- Count up (digit chain):
  - Digit 0 increments.
  - A digit at modulus-1 rolls to 0 and carries into the next digit.
  - When the carry leaves the MSD, all digits are 0: wrap_out pulses together with tick_out and counting continues.
- Count down (digit chain):
  - Digit 0 decrements.
  - A digit at 0 rolls to modulus-1 and borrows from the next digit.
  - When the step result is all-zero: tick_out pulses, state -> DONE, done_out high from that same cycle, prescaler 0.
  - Borrow never leaves the MSD.
- DONE: digits hold. Only clear, load or reset exit. start and stop are ignored.
- A dir_sbt change takes effect at the next step only; the prescaler is not reset.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package sb_timer_pkg holds:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - DIGIT_W
  - a function extracting a modulus field from DIGIT_MOD
  - a function clamping a load field to its modulus
- Sub-module sb_digit_cell, generated NUM_DIGITS times:
  - parameter MOD
  - inputs: clk, rst, step_en, dir, carry_in, load, load_val
  - outputs: digit, carry_out (covering both carry and borrow)
  - carry_in of digit 0 = step.

Test Plan (ONE_SEC=4, defaults otherwise):
- Reset then start, dir=0: tick_out every 4 cycles. digits_out reads 0x0001 four cycles after start sampled, and 0x0009 then 0x0010 across the 9->10 s boundary.
- load 0x5959, dir=0, start: after one step digits_out=0x0000 with wrap_out and tick_out high for the same single cycle; running_out stays 1.
- load 0x0100, dir=1, start: steps give 0x0059, 0x0058, ... Reaching 0x0000 raises done_out with tick_out. A later start leaves state DONE and digits 0x0000.
- Mid-run stop after 2 prescaler cycles, hold 10 cycles, start: next step occurs exactly 2 cycles after resume; no tick while paused.
- Simultaneous clear+load+start: clear wins, giving digits 0, IDLE, running_out 0. load_val 0x7F9C yields clamped 0x5959 in PAUSE.
- rst_sbt asserted mid-RUN: all outputs 0 on the next edge. dir=1 with start on all-zero gives done_out=1 and no tick_out.

Source files
------------

// File: rtl/sb_timer_pkg.sv
// sb_timer_pkg: shared types and helpers for the scoreboard timer.
//   state_e      - controller states
//   DIGIT_W      - default bits per digit
//   mod_field    - extracts one digit's modulus from the packed modulus vector
//   clamp_field  - limits a preload field to modulus-1
package sb_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Field idx of a packed vector of w-bit fields, field 0 in the LSBs.
  function automatic int unsigned mod_field(input logic [63:0] mods,
                                            input int idx, input int w);
    logic [63:0] mask;
    logic [63:0] sh;
    mask = (64'd1 << w) - 64'd1;
    sh   = (mods >> (idx * w)) & mask;
    return sh[31:0];
  endfunction

  function automatic logic [7:0] clamp_field(input logic [7:0] val,
                                             input logic [7:0] modv);
    if (val >= modv) return modv - 8'd1;
    return val;
  endfunction

endpackage

// File: rtl/sb_digit_cell.sv
// sb_digit_cell: one modulo-MOD digit of the timer chain.
//   clk, rst       - clock, synchronous active-high reset
//   step_en        - a count step happens this cycle
//   dir            - 0 = up, 1 = down
//   carry_in       - carry (up) or borrow (down) from the lower digit
//   load, load_val - synchronous preload, load wins over counting
//   digit          - registered digit value
//   carry_out      - carry/borrow to the next digit (combinational)
module sb_digit_cell #(
  parameter int          W   = 4,
  parameter int unsigned MOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en,
  input  logic         dir,
  input  logic         carry_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] digit,
  output logic         carry_out
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] digit_q, digit_d;
  logic         at_edge;

  // A digit passes carry/borrow on only when it rolls over itself.
  assign at_edge   = dir ? (digit_q == '0) : (digit_q == MAX);
  assign carry_out = step_en & carry_in & at_edge;
  assign digit     = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (step_en && carry_in) begin
      if (dir) digit_d = (digit_q == '0) ? MAX : digit_q - W'(1);
      else     digit_d = (digit_q == MAX) ? '0 : digit_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

endmodule

// File: rtl/sb_timer.sv
// sb_timer: prescaled multi-digit up/down timer feeding the digit mux.
//   clk_sbt, rst_sbt          - clock, synchronous active-high reset
//   start/stop/clear/load_sbt - command pulses, priority clear > load > stop > start
//   load_val_sbt              - preload value, digit 0 in LSBs (clamped per digit)
//   dir_sbt                   - 0 = count up, 1 = count down
//   digits_out                - current digits, digit 0 in LSBs
//   running_out, done_out     - state levels
//   tick_out, wrap_out        - one-cycle pulses aligned with the new digits
//
// state | meaning
// IDLE  | after reset or clear, digits zero
// RUN   | prescaler running, digits step every ONE_SEC cycles
// PAUSE | stopped or freshly loaded, value and prescaler held
// DONE  | count-down reached zero, only clear/load/reset leave
module sb_timer #(
  parameter int ONE_SEC    = 25000000,
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DIGIT_MOD = {4'd6, 4'd10, 4'd6, 4'd10}
) (
  input  logic                          clk_sbt,
  input  logic                          rst_sbt,
  input  logic                          start_sbt,
  input  logic                          stop_sbt,
  input  logic                          clear_sbt,
  input  logic                          load_sbt,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val_sbt,
  input  logic                          dir_sbt,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits_out,
  output logic                          running_out,
  output logic                          tick_out,
  output logic                          wrap_out,
  output logic                          done_out
);

  import sb_timer_pkg::*;

  localparam int NW = NUM_DIGITS * DIGIT_W;
  localparam int PW = $clog2(ONE_SEC);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            running_q, running_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            done_q, done_d;

  logic [NW-1:0]         digits_w;
  logic [NW-1:0]         load_bus;
  logic [NUM_DIGITS:0]   carry;
  logic                  presc_tc, all_zero, is_one, step, cell_load;

  assign presc_tc  = (presc_q == PW'(ONE_SEC - 1));
  assign all_zero  = (digits_w == '0);
  // A down step lands on zero only from exactly 1: any other borrow refills digit 0.
  assign is_one    = (digits_w == NW'(1));
  // A down step from zero would borrow out of the MSD, so it is suppressed.
  assign step      = (state_q == ST_RUN) && !clear_sbt && !load_sbt && !stop_sbt &&
                     presc_tc && !(dir_sbt && all_zero);
  assign cell_load = clear_sbt | load_sbt;
  assign carry[0]  = step;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned MOD_I = mod_field(64'(DIGIT_MOD), i, DIGIT_W);
    logic [DIGIT_W-1:0] clamped;

    assign clamped = DIGIT_W'(clamp_field(8'(load_val_sbt[i*DIGIT_W +: DIGIT_W]), 8'(MOD_I)));
    assign load_bus[i*DIGIT_W +: DIGIT_W] = clear_sbt ? '0 : clamped;

    sb_digit_cell #(.W(DIGIT_W), .MOD(MOD_I)) u_cell (
      .clk       (clk_sbt),
      .rst       (rst_sbt),
      .step_en   (step),
      .dir       (dir_sbt),
      .carry_in  (carry[i]),
      .load      (cell_load),
      .load_val  (load_bus[i*DIGIT_W +: DIGIT_W]),
      .digit     (digits_w[i*DIGIT_W +: DIGIT_W]),
      .carry_out (carry[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (clear_sbt) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (load_sbt) begin
      state_d = ST_PAUSE;
      presc_d = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stop_sbt) begin
            state_d = ST_PAUSE;
          end else if (presc_tc) begin
            presc_d = '0;
            if (dir_sbt && all_zero) begin
              state_d = ST_DONE;
            end else begin
              tick_d = 1'b1;
              if (dir_sbt && is_one) state_d = ST_DONE;
              if (!dir_sbt && carry[NUM_DIGITS]) wrap_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start_sbt) state_d = (dir_sbt && all_zero) ? ST_DONE : ST_RUN;
        end
        default: ;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_sbt) begin
    if (rst_sbt) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
    end
  end

  assign digits_out  = digits_w;
  assign running_out = running_q;
  assign tick_out    = tick_q;
  assign wrap_out    = wrap_q;
  assign done_out    = done_q;

endmodule
